// File: rtl/csr_access_ctrl.sv
// CSR storage sequencer: serialises CSR-instruction read-modify-write and
// trap-entry save/fetch sequences onto a single-port, one-cycle-read RAM.
module csr_access_ctrl #(
   parameter int unsigned         WIDTH       = 32,
   parameter int unsigned         ADDR_W      = 12,
   parameter logic [ADDR_W-1:0]   MEPC_ADDR   = 12'h341,
   parameter logic [ADDR_W-1:0]   MCAUSE_ADDR = 12'h342,
   parameter logic [ADDR_W-1:0]   MTVEC_ADDR  = 12'h305
) (
   input  logic              clock,
   input  logic              reset_n,
   // CSR instruction port
   input  logic              inst_valid,
   output logic              inst_ready,
   input  logic [1:0]        inst_op,
   input  logic [ADDR_W-1:0] inst_addr,
   input  logic [WIDTH-1:0]  inst_wdata,
   input  logic [4:0]        inst_rs1,
   output logic              resp_valid,
   output logic [WIDTH-1:0]  resp_rdata,
   // Trap entry port
   input  logic              trap_valid,
   output logic              trap_ready,
   input  logic [WIDTH-1:0]  trap_pc,
   input  logic [WIDTH-1:0]  trap_cause,
   output logic              trap_done,
   output logic [WIDTH-1:0]  trap_vector,
   // CSR RAM port
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_write_en,
   output logic [WIDTH-1:0]  mem_wdata,
   input  logic [WIDTH-1:0]  mem_rdata
);

   typedef enum logic [2:0] {
      IDLE, I_RD, I_WR, T_EPC, T_CAUSE, T_VEC, T_DONE
   } state_t;

   localparam logic [1:0] OP_RW = 2'b01;
   localparam logic [1:0] OP_RS = 2'b10;
   localparam logic [1:0] OP_RC = 2'b11;

   state_t              state, state_next;
   logic [1:0]          op_q;
   logic [ADDR_W-1:0]   addr_q;
   logic [WIDTH-1:0]    wdata_q;
   logic [4:0]          rs1_q;
   logic [WIDTH-1:0]    pc_q;
   logic [WIDTH-1:0]    cause_q;
   logic                trap_acc;
   logic                inst_acc;
   logic [WIDTH-1:0]    rmw_value;
   logic                rmw_write;

   // Ready lines are forced low while reset is held so nothing can be
   // accepted in the same cycle the sequencer is being cleared.
   assign trap_ready = reset_n && (state == IDLE);
   assign inst_ready = reset_n && (state == IDLE) && !trap_valid;
   assign trap_acc   = trap_valid && trap_ready;
   assign inst_acc   = inst_valid && inst_ready;

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of process evaluation order.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         op_q    <= '0;
         addr_q  <= '0;
         wdata_q <= '0;
         rs1_q   <= '0;
         pc_q    <= '0;
         cause_q <= '0;
      end else if (trap_acc) begin
         pc_q    <= trap_pc;
         cause_q <= trap_cause;
      end else if (inst_acc) begin
         op_q    <= inst_op;
         addr_q  <= inst_addr;
         wdata_q <= inst_wdata;
         rs1_q   <= inst_rs1;
      end
   end

   // NOTE: every combinational output gets a default before the case so no
   // path through the block leaves a signal unassigned and infers a latch.
   always_comb begin
      state_next = state;
      unique case (state)
         IDLE: begin
            if (trap_acc) begin
               state_next = T_EPC;
            end else if (inst_acc) begin
               state_next = I_RD;
            end
         end
         I_RD:    state_next = I_WR;
         I_WR:    state_next = IDLE;
         T_EPC:   state_next = T_CAUSE;
         T_CAUSE: state_next = T_VEC;
         T_VEC:   state_next = T_DONE;
         T_DONE:  state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Reserved op 00 behaves as a pure read: value unchanged, no write.
   always_comb begin
      rmw_value = mem_rdata;
      rmw_write = 1'b0;
      unique case (op_q)
         OP_RW: begin
            rmw_value = wdata_q;
            rmw_write = 1'b1;
         end
         OP_RS: begin
            rmw_value = mem_rdata | wdata_q;
            rmw_write = (rs1_q != 5'd0);
         end
         OP_RC: begin
            rmw_value = mem_rdata & ~wdata_q;
            rmw_write = (rs1_q != 5'd0);
         end
         default: begin
            rmw_value = mem_rdata;
            rmw_write = 1'b0;
         end
      endcase
   end

   always_comb begin
      mem_addr     = '0;
      mem_write_en = 1'b0;
      mem_wdata    = '0;
      resp_valid   = 1'b0;
      resp_rdata   = '0;
      trap_done    = 1'b0;
      trap_vector  = '0;
      unique case (state)
         I_RD: begin
            mem_addr = addr_q;
         end
         I_WR: begin
            mem_addr     = addr_q;
            mem_write_en = rmw_write;
            mem_wdata    = rmw_value;
            resp_valid   = 1'b1;
            resp_rdata   = mem_rdata;
         end
         T_EPC: begin
            mem_addr     = MEPC_ADDR;
            mem_write_en = 1'b1;
            mem_wdata    = pc_q;
         end
         T_CAUSE: begin
            mem_addr     = MCAUSE_ADDR;
            mem_write_en = 1'b1;
            mem_wdata    = cause_q;
         end
         T_VEC: begin
            mem_addr = MTVEC_ADDR;
         end
         T_DONE: begin
            trap_done   = 1'b1;
            trap_vector = {mem_rdata[WIDTH-1:2], 2'b00};
         end
         default: begin
            mem_addr = '0;
         end
      endcase
   end

endmodule

// File: tb/tb_csr_access_ctrl.sv
// Self-checking bench for csr_access_ctrl: a behavioural CSR RAM, a reference
// copy of its contents, and scoreboards filled on acceptance, drained on output.
module tb_csr_access_ctrl;

   localparam int WIDTH  = 32;
   localparam int ADDR_W = 12;

   logic              clock = 1'b0;
   logic              reset_n = 1'b0;
   logic              inst_valid = 1'b0;
   logic              inst_ready;
   logic [1:0]        inst_op = '0;
   logic [ADDR_W-1:0] inst_addr = '0;
   logic [WIDTH-1:0]  inst_wdata = '0;
   logic [4:0]        inst_rs1 = '0;
   logic              resp_valid;
   logic [WIDTH-1:0]  resp_rdata;
   logic              trap_valid = 1'b0;
   logic              trap_ready;
   logic [WIDTH-1:0]  trap_pc = '0;
   logic [WIDTH-1:0]  trap_cause = '0;
   logic              trap_done;
   logic [WIDTH-1:0]  trap_vector;
   logic [ADDR_W-1:0] mem_addr;
   logic              mem_write_en;
   logic [WIDTH-1:0]  mem_wdata;
   logic [WIDTH-1:0]  mem_rdata;

   csr_access_ctrl #(
      .WIDTH(WIDTH), .ADDR_W(ADDR_W),
      .MEPC_ADDR(12'h341), .MCAUSE_ADDR(12'h342), .MTVEC_ADDR(12'h305)
   ) dut (
      .clock(clock), .reset_n(reset_n),
      .inst_valid(inst_valid), .inst_ready(inst_ready), .inst_op(inst_op),
      .inst_addr(inst_addr), .inst_wdata(inst_wdata), .inst_rs1(inst_rs1),
      .resp_valid(resp_valid), .resp_rdata(resp_rdata),
      .trap_valid(trap_valid), .trap_ready(trap_ready), .trap_pc(trap_pc),
      .trap_cause(trap_cause), .trap_done(trap_done), .trap_vector(trap_vector),
      .mem_addr(mem_addr), .mem_write_en(mem_write_en), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata)
   );

   always #5 clock = ~clock;

   int cyc = 0;
   always @(posedge clock) cyc <= cyc + 1;

   // Single-port CSR RAM with registered read; preload port used only while idle.
   bit   [WIDTH-1:0]  mem [0:4095];
   logic              pre_en = 1'b0;
   logic [ADDR_W-1:0] pre_addr = '0;
   logic [WIDTH-1:0]  pre_data = '0;
   always @(posedge clock) begin
      if (pre_en) mem[pre_addr] <= pre_data;
      else if (mem_write_en) mem[mem_addr] <= mem_wdata;
      mem_rdata <= mem[mem_addr];
   end

   typedef struct {
      logic [1:0]        op;
      logic [ADDR_W-1:0] addr;
      logic [WIDTH-1:0]  wdata;
      logic [4:0]        rs1;
   } inst_req_t;
   typedef struct {
      logic [WIDTH-1:0] pc;
      logic [WIDTH-1:0] cause;
   } trap_req_t;
   typedef struct {
      logic [WIDTH-1:0]  rdata;
      logic              we;
      logic [ADDR_W-1:0] addr;
      int                acc;
   } inst_exp_t;
   typedef struct {
      logic [WIDTH-1:0] vec;
      logic [WIDTH-1:0] pc;
      logic [WIDTH-1:0] cause;
      int               acc;
   } trap_exp_t;

   inst_req_t  inst_stim[$];
   trap_req_t  trap_stim[$];
   inst_exp_t  inst_sb[$];
   trap_exp_t  trap_sb[$];
   int         acc_log[$];
   bit [WIDTH-1:0] ref_mem [0:4095];
   int n_checks = 0;
   int n_fail = 0;
   int last_inst_acc = 0;
   int last_trap_acc = 0;

   task automatic preload(input logic [ADDR_W-1:0] a, input logic [WIDTH-1:0] d);
      @(posedge clock); #1;
      pre_en = 1'b1; pre_addr = a; pre_data = d;
      @(posedge clock); #1;
      pre_en = 1'b0;
      ref_mem[a] = d;
   endtask

   task automatic drive_next_inst();
      inst_req_t r;
      if (inst_stim.size() != 0) begin
         r = inst_stim.pop_front();
         inst_valid = 1'b1; inst_op = r.op; inst_addr = r.addr;
         inst_wdata = r.wdata; inst_rs1 = r.rs1;
      end else begin
         inst_valid = 1'b0; inst_op = '0; inst_addr = '0;
         inst_wdata = '0; inst_rs1 = '0;
      end
   endtask

   task automatic drive_next_trap();
      trap_req_t r;
      if (trap_stim.size() != 0) begin
         r = trap_stim.pop_front();
         trap_valid = 1'b1; trap_pc = r.pc; trap_cause = r.cause;
      end else begin
         trap_valid = 1'b0; trap_pc = '0; trap_cause = '0;
      end
   endtask

   // Presents queued requests, scores every response/trap completion and the
   // RAM traffic of in-flight sequences until both scoreboards drain.
   task automatic run_sequence(input int budget);
      int             spent = 0;
      bit             acc_i;
      bit             acc_t;
      inst_exp_t      ie;
      trap_exp_t      te;
      logic [WIDTH-1:0] old_v;
      logic [WIDTH-1:0] new_v;
      logic           we_v;
      @(posedge clock); #1;
      drive_next_inst();
      drive_next_trap();
      while (inst_valid || trap_valid || inst_sb.size() != 0 || trap_sb.size() != 0) begin
         if (spent >= budget) begin
            n_checks++; n_fail++;
            $display("FAIL sequence_timeout: used %0d cycles, required completion within %0d", spent, budget);
            inst_sb.delete(); trap_sb.delete(); inst_stim.delete(); trap_stim.delete();
            inst_valid = 1'b0; trap_valid = 1'b0;
            break;
         end
         spent++;
         @(negedge clock);
         if (inst_sb.size() != 0 && cyc == inst_sb[0].acc) begin
            n_checks++;
            if (mem_addr !== inst_sb[0].addr || mem_write_en !== 1'b0) begin
               n_fail++;
               $display("FAIL inst_read_phase: addr=%h we=%b, required addr=%h we=0", mem_addr, mem_write_en, inst_sb[0].addr);
            end
         end
         if (resp_valid === 1'b1) begin
            n_checks++;
            if (inst_sb.size() == 0) begin
               n_fail++;
               $display("FAIL unexpected_resp: resp_valid=1 rdata=%h, required no response", resp_rdata);
            end else begin
               ie = inst_sb.pop_front();
               if (resp_rdata !== ie.rdata || mem_write_en !== ie.we || cyc != ie.acc + 1 || trap_done !== 1'b0) begin
                  n_fail++;
                  $display("FAIL inst_resp: rdata=%h we=%b cycle=%0d trap_done=%b, required rdata=%h we=%b cycle=%0d trap_done=0",
                           resp_rdata, mem_write_en, cyc, trap_done, ie.rdata, ie.we, ie.acc + 1);
               end
            end
         end
         if (trap_sb.size() != 0) begin
            te = trap_sb[0];
            if (cyc == te.acc) begin
               n_checks++;
               if (mem_addr !== 12'h341 || mem_write_en !== 1'b1 || mem_wdata !== te.pc) begin
                  n_fail++;
                  $display("FAIL trap_mepc_write: addr=%h we=%b data=%h, required addr=341 we=1 data=%h", mem_addr, mem_write_en, mem_wdata, te.pc);
               end
            end else if (cyc == te.acc + 1) begin
               n_checks++;
               if (mem_addr !== 12'h342 || mem_write_en !== 1'b1 || mem_wdata !== te.cause) begin
                  n_fail++;
                  $display("FAIL trap_mcause_write: addr=%h we=%b data=%h, required addr=342 we=1 data=%h", mem_addr, mem_write_en, mem_wdata, te.cause);
               end
            end else if (cyc == te.acc + 2) begin
               n_checks++;
               if (mem_addr !== 12'h305 || mem_write_en !== 1'b0) begin
                  n_fail++;
                  $display("FAIL trap_mtvec_read: addr=%h we=%b, required addr=305 we=0", mem_addr, mem_write_en);
               end
            end
         end
         if (trap_done === 1'b1) begin
            n_checks++;
            if (trap_sb.size() == 0) begin
               n_fail++;
               $display("FAIL unexpected_trap_done: vector=%h, required no trap completion", trap_vector);
            end else begin
               te = trap_sb.pop_front();
               if (trap_vector !== te.vec || cyc != te.acc + 3 || resp_valid !== 1'b0) begin
                  n_fail++;
                  $display("FAIL trap_done: vector=%h cycle=%0d resp_valid=%b, required vector=%h cycle=%0d resp_valid=0",
                           trap_vector, cyc, resp_valid, te.vec, te.acc + 3);
               end
            end
         end
         acc_t = trap_valid && (trap_ready === 1'b1);
         acc_i = inst_valid && (inst_ready === 1'b1);
         if (acc_t) begin
            n_checks++;
            if (inst_ready !== 1'b0) begin
               n_fail++;
               $display("FAIL trap_priority: inst_ready=%b with trap accepted, required 0", inst_ready);
            end
            te.vec   = {ref_mem[12'h305][WIDTH-1:2], 2'b00};
            te.pc    = trap_pc;
            te.cause = trap_cause;
            te.acc   = cyc + 1;
            trap_sb.push_back(te);
            ref_mem[12'h341] = trap_pc;
            ref_mem[12'h342] = trap_cause;
            last_trap_acc = cyc + 1;
         end else if (acc_i) begin
            old_v = ref_mem[inst_addr];
            case (inst_op)
               2'b01:   begin new_v = inst_wdata;          we_v = 1'b1; end
               2'b10:   begin new_v = old_v | inst_wdata;  we_v = (inst_rs1 != 5'd0); end
               2'b11:   begin new_v = old_v & ~inst_wdata; we_v = (inst_rs1 != 5'd0); end
               default: begin new_v = old_v;               we_v = 1'b0; end
            endcase
            ie.rdata = old_v;
            ie.we    = we_v;
            ie.addr  = inst_addr;
            ie.acc   = cyc + 1;
            inst_sb.push_back(ie);
            if (we_v) ref_mem[inst_addr] = new_v;
            acc_log.push_back(cyc + 1);
            last_inst_acc = cyc + 1;
         end
         @(posedge clock); #1;
         if (acc_i && !acc_t) drive_next_inst();
         if (acc_t) drive_next_trap();
      end
   endtask

   task automatic test_reset();
      inst_valid = 1'b1;
      #3;
      n_checks++;
      if ({inst_ready, trap_ready, resp_valid, trap_done, mem_write_en} !== 5'b0 ||
          resp_rdata !== '0 || trap_vector !== '0 || mem_addr !== '0 || mem_wdata !== '0) begin
         n_fail++;
         $display("FAIL reset_outputs: ready=%b/%b valid=%b/%b we=%b addr=%h, required all zero",
                  inst_ready, trap_ready, resp_valid, trap_done, mem_write_en, mem_addr);
      end
      repeat (2) @(negedge clock);
      inst_valid = 1'b0;
      reset_n = 1'b1;
      #1;
      n_checks++;
      if (inst_ready !== 1'b1 || trap_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL idle_ready: inst_ready=%b trap_ready=%b, required 1/1", inst_ready, trap_ready);
      end
   endtask

   task automatic test_csrrw();
      preload(12'h300, 32'h0000_1888);
      inst_stim.push_back('{2'b01, 12'h300, 32'h0000_0008, 5'd5});
      run_sequence(50);
      #1;
      n_checks++;
      if (mem[12'h300] !== 32'h0000_0008) begin
         n_fail++;
         $display("FAIL csrrw_mem: mem[300]=%h, required 00000008", mem[12'h300]);
      end
   endtask

   task automatic test_csrrs_csrrc();
      preload(12'h304, 32'h0000_00F0);
      inst_stim.push_back('{2'b10, 12'h304, 32'h0000_000F, 5'd1});
      inst_stim.push_back('{2'b11, 12'h304, 32'h0000_000F, 5'd0});
      inst_stim.push_back('{2'b00, 12'h304, 32'hFFFF_FFFF, 5'd3});
      inst_stim.push_back('{2'b11, 12'h304, 32'h0000_0030, 5'd2});
      run_sequence(80);
      #1;
      n_checks++;
      if (mem[12'h304] !== 32'h0000_00CF) begin
         n_fail++;
         $display("FAIL rs_rc_mem: mem[304]=%h, required 000000cf", mem[12'h304]);
      end
   endtask

   task automatic test_trap();
      preload(12'h305, 32'h0000_1001);
      trap_stim.push_back('{32'h8000_0040, 32'h8000_0007});
      run_sequence(50);
      #1;
      n_checks++;
      if (mem[12'h341] !== 32'h8000_0040 || mem[12'h342] !== 32'h8000_0007) begin
         n_fail++;
         $display("FAIL trap_mem: mepc=%h mcause=%h, required 80000040/80000007", mem[12'h341], mem[12'h342]);
      end
   endtask

   task automatic test_arbitration();
      trap_stim.push_back('{32'h1234_5678, 32'h0000_000B});
      inst_stim.push_back('{2'b10, 12'h341, 32'h0000_0000, 5'd0});
      run_sequence(60);
      n_checks++;
      if (last_inst_acc - last_trap_acc != 5) begin
         n_fail++;
         $display("FAIL arb_inst_accept: accepted %0d cycles after trap, required 5", last_inst_acc - last_trap_acc);
      end
   endtask

   task automatic test_back_to_back();
      preload(12'h340, 32'h0000_A5A5);
      acc_log.delete();
      for (int i = 1; i <= 3; i++)
         inst_stim.push_back('{2'b01, 12'h340, 32'(i * 32'h1111), 5'd1});
      run_sequence(60);
      n_checks++;
      if (acc_log.size() != 3 || acc_log[1] - acc_log[0] != 3 || acc_log[2] - acc_log[1] != 3) begin
         n_fail++;
         $display("FAIL b2b_spacing: %0d accepts, gaps %0d/%0d, required 3 accepts with gaps 3/3",
                  acc_log.size(), (acc_log.size() > 1) ? acc_log[1] - acc_log[0] : -1,
                  (acc_log.size() > 2) ? acc_log[2] - acc_log[1] : -1);
      end
   endtask

   task automatic test_reset_mid();
      bit seen;
      int waited;
      preload(12'h310, 32'h0000_0055);
      @(posedge clock); #1;
      inst_valid = 1'b1; inst_op = 2'b01; inst_addr = 12'h310;
      inst_wdata = 32'h0000_00AA; inst_rs1 = 5'd1;
      waited = 0;
      @(negedge clock);
      while (inst_ready !== 1'b1 && waited < 20) begin
         waited++;
         @(negedge clock);
      end
      n_checks++;
      if (inst_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL reset_mid_accept: inst_ready=%b after %0d cycles, required 1", inst_ready, waited);
      end
      @(posedge clock); #1;
      inst_valid = 1'b0;
      #2;
      reset_n = 1'b0;
      #1;
      n_checks++;
      if (mem_write_en !== 1'b0 || mem_addr !== '0 || resp_valid !== 1'b0 || inst_ready !== 1'b0 || trap_ready !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_mid_outputs: we=%b addr=%h resp=%b ready=%b/%b, required all zero",
                  mem_write_en, mem_addr, resp_valid, inst_ready, trap_ready);
      end
      seen = 1'b0;
      repeat (3) begin
         @(negedge clock);
         if (resp_valid !== 1'b0 || mem_write_en !== 1'b0) seen = 1'b1;
      end
      reset_n = 1'b1;
      repeat (4) begin
         @(negedge clock);
         if (resp_valid !== 1'b0 || mem_write_en !== 1'b0) seen = 1'b1;
      end
      n_checks++;
      if (seen || mem[12'h310] !== 32'h0000_0055) begin
         n_fail++;
         $display("FAIL reset_mid_abort: stray activity=%b mem[310]=%h, required 0 and 00000055", seen, mem[12'h310]);
      end
   endtask

   initial begin
      test_reset();
      test_csrrw();
      test_csrrs_csrrc();
      test_trap();
      test_arbitration();
      test_back_to_back();
      test_reset_mid();
      test_csrrw();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
